// File: rtl/error_recovery_ctrl.sv
// Pipeline error recovery: flush, replay from the last good PC, then watch for a quiet
// period; repeated or unflushable errors escalate to a sticky fatal state.
module error_recovery_ctrl #(
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned FLUSH_TIMEOUT = 64,
   parameter int unsigned QUIET_COMMITS = 16
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        error_in,
   input  logic [7:0]  error_src,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic        flush_ack,
   input  logic        clear_fatal,
   output logic        flush_req,
   output logic        stall_fetch,
   output logic        replay_req,
   output logic [31:0] replay_pc,
   output logic        fatal_irq,
   output logic [1:0]  retry_cnt,
   output logic [7:0]  err_log,
   output logic [2:0]  state_o
);

   localparam int unsigned TW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
   localparam int unsigned QW = (QUIET_COMMITS > 1) ? $clog2(QUIET_COMMITS + 1) : 1;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StFlush   = 3'd1,
      StReplay  = 3'd2,
      StMonitor = 3'd3,
      StFatal   = 3'd4
   } state_e;

   state_e        state_q;
   logic [31:0]   last_good_pc_q;
   logic [TW-1:0] tmo_cnt_q;
   logic [QW-1:0] quiet_cnt_q;
   logic          retry_avail;

   assign retry_avail = 32'(retry_cnt) < MAX_RETRY;
   assign state_o     = state_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q        <= StIdle;
         last_good_pc_q <= '0;
         tmo_cnt_q      <= '0;
         quiet_cnt_q    <= '0;
         flush_req      <= 1'b0;
         stall_fetch    <= 1'b0;
         replay_req     <= 1'b0;
         replay_pc      <= '0;
         fatal_irq      <= 1'b0;
         retry_cnt      <= '0;
         err_log        <= '0;
      end else begin
         // Sticky error history; a fatal clear below overrides this.
         if (error_in) err_log <= err_log | error_src;

         unique case (state_q)
            StIdle, StMonitor: begin
               // A commit retiring alongside the error still counts as good.
               if (commit_valid) last_good_pc_q <= commit_pc;
               if (error_in) begin
                  stall_fetch <= 1'b1;
                  if (retry_avail) begin
                     retry_cnt <= retry_cnt + 2'd1;
                     state_q   <= StFlush;
                     flush_req <= 1'b1;
                     tmo_cnt_q <= '0;
                  end else begin
                     state_q   <= StFatal;
                     fatal_irq <= 1'b1;
                  end
               end else if (state_q == StMonitor && commit_valid) begin
                  if (quiet_cnt_q == QW'(QUIET_COMMITS - 1)) begin
                     state_q     <= StIdle;
                     retry_cnt   <= '0;
                     quiet_cnt_q <= '0;
                  end else begin
                     quiet_cnt_q <= quiet_cnt_q + 1'b1;
                  end
               end
            end
            StFlush: begin
               // flush_ack wins over a simultaneous timeout expiry.
               if (flush_ack) begin
                  state_q    <= StReplay;
                  flush_req  <= 1'b0;
                  replay_req <= 1'b1;
                  replay_pc  <= last_good_pc_q + 32'd4;
               end else if (tmo_cnt_q == TW'(FLUSH_TIMEOUT - 1)) begin
                  state_q   <= StFatal;
                  flush_req <= 1'b0;
                  fatal_irq <= 1'b1;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            StReplay: begin
               state_q     <= StMonitor;
               replay_req  <= 1'b0;
               stall_fetch <= 1'b0;
               quiet_cnt_q <= '0;
            end
            StFatal: begin
               if (clear_fatal) begin
                  state_q     <= StIdle;
                  fatal_irq   <= 1'b0;
                  stall_fetch <= 1'b0;
                  retry_cnt   <= '0;
                  err_log     <= '0;
               end
            end
            default: begin
               state_q     <= StIdle;
               flush_req   <= 1'b0;
               stall_fetch <= 1'b0;
               replay_req  <= 1'b0;
               fatal_irq   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_error_recovery_ctrl.sv
// Directed bench for error_recovery_ctrl: recovery, quiet period, escalation,
// flush timeout, and asynchronous reset.
module tb_error_recovery_ctrl;

   logic        clk;
   logic        nrst;
   logic        error_in;
   logic [7:0]  error_src;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic        flush_ack;
   logic        clear_fatal;
   logic        flush_req;
   logic        stall_fetch;
   logic        replay_req;
   logic [31:0] replay_pc;
   logic        fatal_irq;
   logic [1:0]  retry_cnt;
   logic [7:0]  err_log;
   logic [2:0]  state_o;

   int n_checks = 0;
   int n_fail   = 0;

   error_recovery_ctrl dut (
      .clk          (clk),
      .nrst         (nrst),
      .error_in     (error_in),
      .error_src    (error_src),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .flush_ack    (flush_ack),
      .clear_fatal  (clear_fatal),
      .flush_req    (flush_req),
      .stall_fetch  (stall_fetch),
      .replay_req   (replay_req),
      .replay_pc    (replay_pc),
      .fatal_irq    (fatal_irq),
      .retry_cnt    (retry_cnt),
      .err_log      (err_log),
      .state_o      (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nrst = 1'b0; error_in = 1'b0; error_src = 8'h00; commit_valid = 1'b0;
      commit_pc = 32'h0; flush_ack = 1'b0; clear_fatal = 1'b0;
      #3;
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_flush_req", 32'(flush_req), 32'd0);
      check("rst_stall", 32'(stall_fetch), 32'd0);
      check("rst_fatal", 32'(fatal_irq), 32'd0);
      check("rst_retry", 32'(retry_cnt), 32'd0);
      check("rst_err_log", 32'(err_log), 32'd0);
      check("rst_replay_pc", replay_pc, 32'd0);
      #9 nrst = 1'b1;

      // Commit 0x100, then error 0x04 -> FLUSH
      commit_valid = 1'b1; commit_pc = 32'h100; tick();
      commit_valid = 1'b0; error_in = 1'b1; error_src = 8'h04; tick();
      error_in = 1'b0; error_src = 8'h00;
      check("t1_state_flush", 32'(state_o), 32'd1);
      check("t1_flush_req", 32'(flush_req), 32'd1);
      check("t1_stall", 32'(stall_fetch), 32'd1);
      check("t1_retry", 32'(retry_cnt), 32'd1);
      check("t1_err_log", 32'(err_log), 32'h04);
      for (int i = 0; i < 4; i++) tick();
      check("t1_still_flush", 32'(state_o), 32'd1);
      flush_ack = 1'b1; tick(); flush_ack = 1'b0;
      check("t1_state_replay", 32'(state_o), 32'd2);
      check("t1_replay_req", 32'(replay_req), 32'd1);
      check("t1_replay_pc", replay_pc, 32'h104);
      check("t1_replay_flush_req", 32'(flush_req), 32'd0);
      check("t1_replay_stall", 32'(stall_fetch), 32'd1);
      tick();
      check("t1_state_monitor", 32'(state_o), 32'd3);
      check("t1_mon_replay_req", 32'(replay_req), 32'd0);
      check("t1_mon_stall", 32'(stall_fetch), 32'd0);
      check("t1_mon_replay_pc_hold", replay_pc, 32'h104);

      // 16 clean commits in MONITOR -> IDLE
      commit_valid = 1'b1;
      for (int i = 0; i < 15; i++) begin
         commit_pc = 32'h200 + 32'(4 * i);
         tick();
      end
      check("t2_mon_after15", 32'(state_o), 32'd3);
      check("t2_retry_after15", 32'(retry_cnt), 32'd1);
      commit_pc = 32'h23C; tick(); commit_valid = 1'b0;
      check("t2_state_idle", 32'(state_o), 32'd0);
      check("t2_retry_clr", 32'(retry_cnt), 32'd0);
      check("t2_err_log_kept", 32'(err_log), 32'h04);

      // Error from IDLE, then error 0x80 during FLUSH is absorbed
      error_in = 1'b1; error_src = 8'h01; tick();
      check("t3_state_flush", 32'(state_o), 32'd1);
      error_src = 8'h80; tick();
      error_in = 1'b0; error_src = 8'h00;
      check("t3_no_restart_state", 32'(state_o), 32'd1);
      check("t3_no_restart_retry", 32'(retry_cnt), 32'd1);
      check("t3_err_log_bit7", 32'(err_log), 32'h85);
      flush_ack = 1'b1; tick(); flush_ack = 1'b0;
      check("t3_replay_pc", replay_pc, 32'h240);
      tick();

      // Four errors without a quiet period -> FATAL
      commit_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         commit_pc = 32'h300 + 32'(4 * i);
         tick();
      end
      commit_pc = 32'h30C; error_in = 1'b1; error_src = 8'h02; tick();
      commit_valid = 1'b0; error_in = 1'b0;
      check("t4_retry2", 32'(retry_cnt), 32'd2);
      flush_ack = 1'b1; tick(); flush_ack = 1'b0;
      check("t4_replay_pc_coincident", replay_pc, 32'h310);
      tick();
      error_in = 1'b1; error_src = 8'h10; tick(); error_in = 1'b0;
      check("t4_retry3", 32'(retry_cnt), 32'd3);
      flush_ack = 1'b1; tick(); flush_ack = 1'b0;
      tick();
      check("t4_monitor_again", 32'(state_o), 32'd3);
      error_in = 1'b1; error_src = 8'h20; tick(); error_in = 1'b0;
      check("t4_state_fatal", 32'(state_o), 32'd4);
      check("t4_fatal_irq", 32'(fatal_irq), 32'd1);
      check("t4_fatal_stall", 32'(stall_fetch), 32'd1);
      check("t4_fatal_retry", 32'(retry_cnt), 32'd3);
      check("t4_fatal_err_log", 32'(err_log), 32'hB7);
      commit_valid = 1'b1; commit_pc = 32'hDEAD0000; flush_ack = 1'b1; tick();
      commit_valid = 1'b0; flush_ack = 1'b0;
      check("t4_fatal_holds", 32'(state_o), 32'd4);
      clear_fatal = 1'b1; tick(); clear_fatal = 1'b0;
      check("t4_clear_state", 32'(state_o), 32'd0);
      check("t4_clear_err_log", 32'(err_log), 32'h00);
      check("t4_clear_retry", 32'(retry_cnt), 32'd0);
      check("t4_clear_irq", 32'(fatal_irq), 32'd0);

      // Flush timeout: 64 FLUSH cycles without ack -> FATAL
      error_in = 1'b1; error_src = 8'h08; tick(); error_in = 1'b0;
      check("t5_err_log", 32'(err_log), 32'h08);
      clear_fatal = 1'b1; tick(); clear_fatal = 1'b0;
      check("t5_clear_ignored_flush", 32'(state_o), 32'd1);
      for (int i = 0; i < 62; i++) tick();
      check("t5_flush_cycle64", 32'(state_o), 32'd1);
      tick();
      check("t5_timeout_fatal", 32'(state_o), 32'd4);
      check("t5_timeout_irq", 32'(fatal_irq), 32'd1);
      check("t5_timeout_flush_req", 32'(flush_req), 32'd0);
      clear_fatal = 1'b1; tick(); clear_fatal = 1'b0;

      // flush_ack on the 64th FLUSH cycle wins over expiry
      error_in = 1'b1; tick(); error_in = 1'b0;
      for (int i = 0; i < 63; i++) tick();
      flush_ack = 1'b1; tick(); flush_ack = 1'b0;
      check("t6_late_ack_replay", 32'(state_o), 32'd2);
      check("t6_replay_pc_fatal_commit_ignored", replay_pc, 32'h310);
      tick();
      clear_fatal = 1'b1; tick(); clear_fatal = 1'b0;
      check("t6_clear_ignored_monitor", 32'(state_o), 32'd3);
      check("t6_retry_kept", 32'(retry_cnt), 32'd1);

      // Asynchronous reset mid-FLUSH
      error_in = 1'b1; error_src = 8'h40; tick(); error_in = 1'b0;
      check("t7_flush_req_pre", 32'(flush_req), 32'd1);
      #2 nrst = 1'b0;
      #1;
      check("t7_async_flush_req", 32'(flush_req), 32'd0);
      check("t7_async_state", 32'(state_o), 32'd0);
      check("t7_async_retry", 32'(retry_cnt), 32'd0);
      check("t7_async_err_log", 32'(err_log), 32'h00);
      check("t7_async_replay_pc", replay_pc, 32'h0);
      #2 nrst = 1'b1;
      error_in = 1'b1; tick(); error_in = 1'b0;
      flush_ack = 1'b1; tick(); flush_ack = 1'b0;
      check("t7_replay_pc_from_reset", replay_pc, 32'h4);
      check("t7_err_log_after", 32'(err_log), 32'h40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/error_recovery_ctrl.md
ERROR_RECOVERY_CTRL -- requirements
Module: error_recovery_ctrl

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3, meaning the count of recoveries permitted before escalation to fatal.
REQ-002 SHALL have parameter FLUSH_TIMEOUT, default 64, meaning the cycles allowed for flush_ack before escalation.
REQ-003 SHALL have parameter QUIET_COMMITS, default 16, meaning the error-free commits required to declare recovery complete.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port error_in  input  1  aggregated pipeline error flag.
REQ-007 SHALL have port error_src  input  8  per-unit error flags {mult,mmu,lsu,issue,frontend,exec,divider,csr}, bit7..bit0.
REQ-008 SHALL have port commit_valid  input  1  one instruction retired this cycle.
REQ-009 SHALL have port commit_pc  input  32  PC of the retiring instruction.
REQ-010 SHALL have port flush_ack  input  1  pipeline flush complete.
REQ-011 SHALL have port clear_fatal  input  1  software/debug clear of the fatal condition.
REQ-012 SHALL have port flush_req  output  1  pipeline flush request.
REQ-013 SHALL have port stall_fetch  output  1  hold fetch.
REQ-014 SHALL have port replay_req  output  1  single-cycle replay strobe.
REQ-015 SHALL have port replay_pc  output  32  restart address.
REQ-016 SHALL have port fatal_irq  output  1  unrecoverable error indication.
REQ-017 SHALL have port retry_cnt  output  2  recoveries since the last quiet period.
REQ-018 SHALL have port err_log  output  8  sticky OR of error_src since the last clear.
REQ-019 SHALL have port state_o  output  3  current FSM state encoding.

Function
REQ-020 SHALL implement states IDLE=0, FLUSH=1, REPLAY=2, MONITOR=3, FATAL=4, with all outputs registered.
REQ-021 SHALL latch commit_pc into an internal last_good_pc on every commit_valid in IDLE and MONITOR.
REQ-022 SHALL treat a commit_valid coincident with error_in as good, so last_good_pc takes that commit_pc.
REQ-023 SHALL, on error_in in IDLE or MONITOR with retry_cnt < MAX_RETRY, increment retry_cnt and enter FLUSH next cycle.
REQ-024 SHALL, on error_in in IDLE or MONITOR with retry_cnt == MAX_RETRY, enter FATAL with retry_cnt unchanged.
REQ-025 SHALL OR error_src into err_log every cycle error_in is high, in any state.
REQ-026 SHALL, in FLUSH, assert flush_req=1 and stall_fetch=1 and count cycles from 0 in a timeout counter.
REQ-027 SHALL, in FLUSH, go to REPLAY on flush_ack; otherwise, when the timeout counter reaches FLUSH_TIMEOUT-1 without flush_ack, go to FATAL.
REQ-028 SHALL give flush_ack priority when flush_ack and timeout expiry occur in the same cycle.
REQ-029 SHALL, in FLUSH and REPLAY, not restart or escalate on error_in; such errors only update err_log.
REQ-030 SHALL hold REPLAY for exactly one cycle with replay_req=1, stall_fetch=1 and replay_pc=last_good_pc+4 (mod 2^32), then go to MONITOR.
REQ-031 SHALL, in MONITOR, count commit_valid cycles and go to IDLE with retry_cnt cleared to 0 when the count reaches QUIET_COMMITS.
REQ-032 SHALL reset the MONITOR commit count to 0 on every entry to MONITOR.
REQ-033 SHALL, in FATAL, hold fatal_irq=1 and stall_fetch=1, ignore commit_valid and flush_ack, and remain until clear_fatal.
REQ-034 SHALL, on clear_fatal in FATAL, go to IDLE and clear retry_cnt and err_log; clear_fatal SHALL have no effect in other states.
REQ-035 SHALL deassert flush_req, replay_req, stall_fetch and fatal_irq in IDLE and MONITOR.
REQ-036 SHALL hold replay_pc at its last value outside REPLAY.

Reset
REQ-037 SHALL, on nrst low at any time including mid-FLUSH or FATAL, immediately force state IDLE, all outputs 0, retry_cnt=0, err_log=0, last_good_pc=0 and all counters 0.

Verification
REQ-038 SHALL cover: commit_pc=0x100, then error_in with error_src=0x04 -> FLUSH; flush_ack after 5 cycles -> REPLAY one cycle, replay_pc=0x104, retry_cnt=1, err_log=0x04.
REQ-039 SHALL cover: 16 clean commits in MONITOR -> IDLE with retry_cnt=0 and err_log still 0x04.
REQ-040 SHALL cover: four errors, each arriving before 16 clean commits -> FATAL on the fourth error, fatal_irq=1, retry_cnt=3; clear_fatal -> IDLE with err_log=0.
REQ-041 SHALL cover: no flush_ack for 64 cycles in FLUSH -> FATAL; flush_ack arriving on cycle 64 -> REPLAY instead.
REQ-042 SHALL cover: error_in pulses during FLUSH with error_src=0x80 -> no restart, err_log gains bit7.
REQ-043 SHALL cover: nrst asserted mid-FLUSH -> flush_req=0 asynchronously, state_o=0.
